// File: rtl/schematic_counter_4bit_pkg.sv
// Shared width and operand type for the 4-bit registered incrementer.
// Fixed width; the operand is presented as individual bit ports.
package schematic_counter_4bit_pkg;

   localparam int CNT_W = 4;

   typedef logic [CNT_W-1:0] count_t;

   localparam count_t CNT_ZERO = '0;

endpackage

// File: rtl/schematic_counter_4bit_half_adder.sv
// Single-bit half adder, the cell of the ripple incrementer.
// sum = a ^ b, carry = a & b.
module schematic_counter_4bit_half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/schematic_counter_4bit.sv
// Registered incrementer: result <= {d3,d2,d1,d0} + 1 mod 16.
// Ripple chain of half adders feeding four sync-reset flops.
module schematic_counter_4bit
   import schematic_counter_4bit_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         d0,
   input  logic         d1,
   input  logic         d2,
   input  logic         d3,
   output logic [3:0]   result
);

   count_t                operand;
   count_t                sum;
   logic   [CNT_W-1:0]    carry;
   logic                  carry_unused;
   count_t                q;

   assign operand = {d3, d2, d1, d0};

   // Carry-in of 1 into bit 0 makes the chain an incrementer.
   for (genvar i = 0; i < CNT_W; i++) begin : g_ha
      if (i == 0) begin : g_lsb
         schematic_counter_4bit_half_adder u_ha (
            .a     (operand[i]),
            .b     (1'b1),
            .sum   (sum[i]),
            .carry (carry[i])
         );
      end else begin : g_bit
         schematic_counter_4bit_half_adder u_ha (
            .a     (operand[i]),
            .b     (carry[i-1]),
            .sum   (sum[i]),
            .carry (carry[i])
         );
      end
   end

   // The final carry-out is dropped; wrap to zero is the intended behaviour.
   assign carry_unused = carry[CNT_W-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= CNT_ZERO;
      end else begin
         q <= sum;
      end
   end

   assign result = q;

endmodule

// File: tb/tb_schematic_counter_4bit.sv
// Bench for the registered 4-bit incrementer.
// Vector table plus feedback, mid-cycle and reset sequences.
module tb_schematic_counter_4bit;

   logic       clk;
   logic       reset;
   logic       d0, d1, d2, d3;
   logic [3:0] result;

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_q[$];
   string      name_q[$];

   typedef struct {
      logic       rst;
      logic [3:0] d;
      logic [3:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   schematic_counter_4bit dut (
      .clk    (clk),
      .reset  (reset),
      .d0     (d0),
      .d1     (d1),
      .d2     (d2),
      .d3     (d3),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic rst, input logic [3:0] d);
      reset = rst;
      {d3, d2, d1, d0} = d;
   endtask

   task automatic check(input string nm, input logic [3:0] act,
                        input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, req);
      end
   endtask

   task automatic pop_check();
      logic [3:0] e;
      string      n;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: empty queue at compare");
      end else begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check(n, result, e);
      end
   endtask

   task automatic step(input logic rst, input logic [3:0] d,
                       input logic [3:0] e, input string nm);
      @(negedge clk);
      drive(rst, d);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   initial begin
      logic [3:0] fb;
      drive(1'b1, 4'b0000);

      vecs.push_back('{1'b1, 4'b1010, 4'b0000, "reset_overrides_d"});
      vecs.push_back('{1'b0, 4'b0000, 4'b0001, "inc_0"});
      vecs.push_back('{1'b0, 4'b0111, 4'b1000, "ripple_7"});
      vecs.push_back('{1'b0, 4'b1111, 4'b0000, "wrap_15"});
      vecs.push_back('{1'b0, 4'b0101, 4'b0110, "inc_5"});
      vecs.push_back('{1'b0, 4'b1011, 4'b1100, "inc_11"});
      vecs.push_back('{1'b1, 4'b1111, 4'b0000, "reset_over_15"});
      vecs.push_back('{1'b0, 4'b1110, 4'b1111, "inc_14"});
      vecs.push_back('{1'b0, 4'b0011, 4'b0100, "ripple_3"});

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].d, vecs[i].exp, vecs[i].name);
      end

      // Feedback loop from a cleared register: 1..15,0,1.
      step(1'b1, 4'b0000, 4'b0000, "fb_reset");
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         fb = result;
         drive(1'b0, fb);
         exp_q.push_back(4'(k % 16));
         name_q.push_back($sformatf("feedback_%0d", k));
         @(posedge clk);
         #1;
         pop_check();
      end

      // d changes between edges; only the value at the edge counts.
      step(1'b0, 4'b0100, 4'b0101, "pre_midcycle");
      @(negedge clk);
      drive(1'b0, 4'd3);
      #1;
      check("no_comb_path_d3", result, 4'b0101);
      drive(1'b0, 4'd9);
      #1;
      check("no_comb_path_d9", result, 4'b0101);
      exp_q.push_back(4'b1010);
      name_q.push_back("midcycle_d9");
      @(posedge clk);
      #1;
      pop_check();

      // Reset mid-count, then resume from d+1.
      step(1'b0, 4'b1011, 4'b1100, "reach_12");
      step(1'b1, 4'b1100, 4'b0000, "reset_at_12");
      step(1'b0, 4'b0000, 4'b0001, "resume_after_reset");

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
